// File: rtl/cim_mac_if.sv
`default_nettype none
// =============================================================================
// Module   : cim_mac_if
// Brief    : Input-vector and result handshake bundle for cim_mac_engine.
// Revision : 1.0 - initial release
// =============================================================================
interface cim_mac_if #(
    parameter int ROWS = 16,
    parameter int CH   = 4
);
    localparam int ACC_W = 17 + $clog2(ROWS);

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_width;
    logic                  w_width;
    logic                  acm;
    logic [ROWS*8-1:0]     xin;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH*ACC_W-1:0]   dout;

    // Engine side
    modport slave (
        input  in_valid, in_width, w_width, acm, xin, out_ready,
        output in_ready, out_valid, dout
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_width, w_width, acm, xin, out_ready,
        input  in_ready, out_valid, dout
    );
endinterface

`default_nettype wire

// File: rtl/cim_mac_engine.sv
`default_nettype none
// =============================================================================
// Module   : cim_mac_engine
// Brief    : Bit-serial shift-accumulate CIM MAC, ROWS x CH signed-nibble array,
//            4/8b input and weight modes. Define CIM_ACCUM_EN for multi-tile
//            accumulation across vectors.
// Revision : 1.0 - initial release
// =============================================================================
module cim_mac_engine #(
    parameter int ROWS = 16,
    parameter int CH   = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    w_we,
    input  logic [$clog2(ROWS)-1:0] w_row,
    input  logic [CH*4-1:0]         w_data,
    output logic                    w_err,
    output logic                    busy,
    cim_mac_if.slave                bus
);
    localparam int ACC_W = 17 + $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CH*4-1:0]         w_q [ROWS];
    logic [ROWS*8-1:0]       x_q;
    logic                    iw_q;
    logic                    ww_q;
    logic [2:0]              b_q;
    logic signed [ACC_W-1:0] acc_q [CH];
    logic signed [ACC_W-1:0] acc_d [CH];
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    w_err_q;

    logic signed [ACC_W-1:0] ps_s    [CH];
    logic signed [ACC_W-1:0] ps_u    [CH];
    logic signed [ACC_W-1:0] lane_ps [CH];
    logic [CH*ACC_W-1:0]     dout_d;
    logic                    accept;
    logic                    last_bit;
    logic                    keep_acc;

    assign accept   = (state_q == S_IDLE) && bus.in_valid && in_ready_q;
    assign last_bit = (b_q == (iw_q ? 3'd7 : 3'd3));

    // Per-column partial sums of the current bit-plane, as signed and as unsigned nibbles
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            ps_s[c] = '0;
            ps_u[c] = '0;
            for (int r = 0; r < ROWS; r++) begin
                logic [7:0] xb;
                logic [3:0] nib;
                xb  = x_q[8*r +: 8];
                nib = w_q[r][4*c +: 4];
                if (xb[b_q]) begin
                    ps_s[c] = ps_s[c] + {{(ACC_W-4){nib[3]}}, nib};
                    ps_u[c] = ps_u[c] + {{(ACC_W-4){1'b0}}, nib};
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        if (c % 2 == 0) begin : g_even
            assign lane_ps[c] = ww_q ? ((ps_s[c+1] <<< 4) + ps_u[c]) : ps_s[c];
        end else begin : g_odd
            assign lane_ps[c] = ww_q ? '0 : ps_s[c];
        end
        // Final bit-plane carries the negative two's-complement weight
        assign acc_d[c] = last_bit ? (acc_q[c] - (lane_ps[c] <<< b_q))
                                   : (acc_q[c] + (lane_ps[c] <<< b_q));
    end

    always_comb begin
        dout_d = '0;
        for (int c = 0; c < CH; c++) begin
            dout_d[c*ACC_W +: ACC_W] = acc_q[c];
        end
    end

`ifdef CIM_ACCUM_EN
    logic piw_q;
    logic pww_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            piw_q <= 1'b0;
            pww_q <= 1'b0;
        end else if (accept) begin
            piw_q <= bus.in_width;
            pww_q <= bus.w_width;
        end
    end

    assign keep_acc = bus.acm && (bus.in_width == piw_q) && (bus.w_width == pww_q);
`else
    logic acm_unused;
    assign acm_unused = bus.acm;
    assign keep_acc   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            w_err_q     <= 1'b0;
            x_q         <= '0;
            iw_q        <= 1'b0;
            ww_q        <= 1'b0;
            b_q         <= 3'd0;
            for (int r = 0; r < ROWS; r++) w_q[r] <= '0;
            for (int c = 0; c < CH; c++)   acc_q[c] <= '0;
        end else begin
            w_err_q <= 1'b0;
            if (w_we) begin
                if (state_q == S_IDLE) w_q[w_row] <= w_data;
                else                   w_err_q    <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q    <= S_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        x_q        <= bus.xin;
                        iw_q       <= bus.in_width;
                        ww_q       <= bus.w_width;
                        b_q        <= 3'd0;
                        if (!keep_acc) begin
                            for (int c = 0; c < CH; c++) acc_q[c] <= '0;
                        end
                    end
                end
                S_CALC: begin
                    for (int c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
                    b_q <= b_q + 3'd1;
                    if (last_bit) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_d;
    assign busy          = busy_q;
    assign w_err         = w_err_q;

endmodule

`default_nettype wire
